// File: rtl/sync_pkg.sv
// Shared definitions for the Gray pointer synchroniser family.
//   - Gray/binary conversion helpers
//   - priming FSM state encoding
//   - default pointer width
package sync_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int PTR_W        = ADDRSIZE_DEF + 1;

    // Conversion helpers work on a wide vector. Callers zero-extend their
    // pointer and truncate the result. Leading zeros do not change the low
    // bits in either direction, so one function serves every pointer width.
    localparam int MAX_PTR_W = 32;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } prime_state_t;

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Bare multi-flop synchroniser chain with synchronous active-low clear.
// Usable for either FIFO pointer direction.
// Ports:
//   clk    in   1   destination-domain clock
//   clr_n  in   1   synchronous clear, active low
//   d      in   W   asynchronous input (feeds only the first flop)
//   q      out  W   last stage of the chain
module sync_stage_chain #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr_mon.sv
// Synchronises a far-domain Gray FIFO pointer into wclk and monitors it:
// binary form, per-cycle advance, update strobe and sticky jump error.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   PRIME | after reset; chain filling, wq_rbin tracks, no strobe/error
//   RUN   | normal monitoring, held until the next reset
//
// Ports:
//   wclk        in   1            local clock
//   wrst_n      in   1            synchronous reset, active low
//   rptr        in   ADDRSIZE+1   far-domain Gray pointer
//   err_clr     in   1            clears err_jump
//   wq_rptr     out  ADDRSIZE+1   synchronised Gray pointer
//   wq_rbin     out  ADDRSIZE+1   registered binary of wq_rptr
//   wq_rdelta   out  ADDRSIZE+1   advance since previous sample (modular)
//   wq_rupd     out  1            strobe when wq_rdelta != 0
//   err_jump    out  1            sticky: advance exceeded MAX_DELTA
//   prime_busy  out  1            high while priming after reset
module sync_gray_ptr_mon
    import sync_pkg::*;
#(
    parameter int          ADDRSIZE    = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned MAX_DELTA   = 2**ADDRSIZE
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   wq_rptr,
    output logic [ADDRSIZE:0]   wq_rbin,
    output logic [ADDRSIZE:0]   wq_rdelta,
    output logic                wq_rupd,
    output logic                err_jump,
    output logic                prime_busy
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int CNT_W = 3;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_gray_ptr_mon: SYNC_STAGES must be in 2..4");
    end

    sync_stage_chain #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .clk   (wclk),
        .clr_n (wrst_n),
        .d     (rptr),
        .q     (wq_rptr)
    );

    logic [PW-1:0] bin_now;
    logic [PW-1:0] diff;
    logic          too_far;

    assign bin_now = PW'(gray2bin(MAX_PTR_W'(wq_rptr)));
    assign diff    = bin_now - wq_rbin;
    assign too_far = 32'(diff) > MAX_DELTA;

    // Priming FSM. Priming lasts SYNC_STAGES+1 edges so that the flushed
    // chain has refilled and wq_rbin has captured the live pointer before
    // any delta is reported.
    prime_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q <= ST_PRIME;
            cnt_q   <= CNT_W'(SYNC_STAGES + 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_PRIME: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    assign prime_busy = (state_q == ST_PRIME);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wq_rbin   <= '0;
            wq_rdelta <= '0;
            wq_rupd   <= 1'b0;
            err_jump  <= 1'b0;
        end else begin
            wq_rbin <= bin_now;
            if (state_q == ST_RUN) begin
                wq_rdelta <= diff;
                wq_rupd   <= (diff != '0);
            end else begin
                wq_rdelta <= '0;
                wq_rupd   <= 1'b0;
            end
            // A new out-of-range jump takes priority over a clear on the same edge.
            if (state_q == ST_RUN && too_far) begin
                err_jump <= 1'b1;
            end else if (err_clr) begin
                err_jump <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_gray_ptr_mon.sv
module tb_sync_gray_ptr_mon;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [4:0] rptr;
    logic       err_clr;
    logic [4:0] wq_rptr, wq_rbin, wq_rdelta;
    logic       wq_rupd, err_jump, prime_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] rbin;
        logic [4:0] delta;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int         cur_bin = 0;
    logic       err_m   = 1'b0;

    sync_gray_ptr_mon #(
        .ADDRSIZE    (4),
        .SYNC_STAGES (2),
        .MAX_DELTA   (16)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .rptr       (rptr),
        .err_clr    (err_clr),
        .wq_rptr    (wq_rptr),
        .wq_rbin    (wq_rbin),
        .wq_rdelta  (wq_rdelta),
        .wq_rupd    (wq_rupd),
        .err_jump   (err_jump),
        .prime_busy (prime_busy)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wclk);
            #1;
        end
    endtask

    // Drive a new pointer and push the update the monitor should see.
    task automatic move_to(input int b);
        int d;
        exp_t e;
        d = (b - cur_bin) & 31;
        if (d > 16) err_m = 1'b1;
        e.rbin  = 5'(b);
        e.delta = 5'(d);
        e.err   = err_m;
        if (d != 0) exp_q.push_back(e);
        cur_bin = b;
        rptr = gray(b);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge wclk) begin
        if (wq_rupd === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rupd", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_rbin",  32'(wq_rbin),   32'(e.rbin));
                chk("mon_delta", 32'(wq_rdelta), 32'(e.delta));
                chk("mon_err",   32'(err_jump),  32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n  = 1'b0;
        err_clr = 1'b0;
        rptr    = 5'b10110;
        tick(3);
        chk("rst_rptr",  32'(wq_rptr),   0);
        chk("rst_rbin",  32'(wq_rbin),   0);
        chk("rst_delta", 32'(wq_rdelta), 0);
        chk("rst_rupd",  32'(wq_rupd),   0);
        chk("rst_err",   32'(err_jump),  0);
        chk("rst_prime", 32'(prime_busy), 1);

        // Release with gray(9) already present: priming absorbs it.
        rptr    = gray(9);
        cur_bin = 9;
        wrst_n  = 1'b1;
        tick(1);
        chk("prime_e1", 32'(prime_busy), 1);
        tick(1);
        chk("prime_e2", 32'(prime_busy), 1);
        tick(1);
        chk("prime_e3_done", 32'(prime_busy), 0);
        chk("prime_rbin",    32'(wq_rbin),    9);
        chk("prime_delta",   32'(wq_rdelta),  0);
        chk("prime_err",     32'(err_jump),   0);
        tick(2);
        chk("run_idle_rupd", 32'(wq_rupd), 0);

        // Walk to 0 without exceeding the limit: 9 -> 20 -> 0.
        move_to(20); tick(4);
        move_to(0);  tick(4);
        chk("walk_rbin", 32'(wq_rbin), 0);

        // Latency: gray(0) -> gray(1).
        move_to(1);
        tick(1);
        chk("lat_rptr_t1", 32'(wq_rptr), 0);
        tick(1);
        chk("lat_rptr_t2", 32'(wq_rptr), 1);
        chk("lat_rupd_t2", 32'(wq_rupd), 0);
        tick(1);
        chk("lat_rupd_t3",  32'(wq_rupd),   1);
        chk("lat_rbin_t3",  32'(wq_rbin),   1);
        chk("lat_delta_t3", 32'(wq_rdelta), 1);
        tick(1);
        chk("lat_rupd_t4", 32'(wq_rupd), 0);

        // Wrap 31 -> 0.
        move_to(16); tick(4);
        move_to(31); tick(4);
        move_to(0);  tick(3);
        chk("wrap_rbin",  32'(wq_rbin),   0);
        chk("wrap_delta", 32'(wq_rdelta), 1);
        chk("wrap_rupd",  32'(wq_rupd),   1);
        chk("wrap_err",   32'(err_jump),  0);
        tick(1);

        // Multi-step advance.
        move_to(3); tick(4);
        move_to(7); tick(3);
        chk("jump4_delta", 32'(wq_rdelta), 4);
        chk("jump4_err",   32'(err_jump),  0);
        tick(1);
        move_to(20); tick(4);
        move_to(0);  tick(4);

        // Illegal jump 0 -> 20.
        move_to(20); tick(3);
        chk("jump20_delta", 32'(wq_rdelta), 20);
        chk("jump20_rbin",  32'(wq_rbin),   20);
        chk("jump20_err",   32'(err_jump),  1);
        tick(4);
        chk("err_sticky", 32'(err_jump), 1);

        err_clr = 1'b1; tick(1); err_clr = 1'b0; err_m = 1'b0;
        chk("err_cleared", 32'(err_jump), 0);

        // Clear on the same edge as a new illegal jump (20 -> 6, delta 18).
        move_to(6);
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("setclr_delta", 32'(wq_rdelta), 18);
        chk("setclr_err",   32'(err_jump),  1);
        tick(1);
        chk("setclr_err_hold", 32'(err_jump), 1);

        err_clr = 1'b1; tick(1); err_clr = 1'b0; err_m = 1'b0;
        move_to(12); tick(4);
        chk("pre_rst_rbin", 32'(wq_rbin), 12);

        // Reset pulse in RUN with a nonzero pointer present.
        wrst_n = 1'b0;
        tick(1);
        wrst_n = 1'b1;
        chk("rst2_rptr",  32'(wq_rptr),    0);
        chk("rst2_rbin",  32'(wq_rbin),    0);
        chk("rst2_prime", 32'(prime_busy), 1);
        tick(2);
        chk("rst2_prime_e2", 32'(prime_busy), 1);
        tick(1);
        chk("rst2_prime_done", 32'(prime_busy), 0);
        chk("rst2_rbin_final", 32'(wq_rbin),    12);
        chk("rst2_delta",      32'(wq_rdelta),  0);
        chk("rst2_err",        32'(err_jump),   0);
        tick(3);
        chk("rst2_rupd", 32'(wq_rupd), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
